pipeline_hazard_ctrl: RTL and testbench

//  Parametrised hazard/stall controller for the 5-stage MIPS pipeline; drives PC/IF-ID write enables, ID/EX bubble and PC source select.

---
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the ID-stage decode and the hazard/stall controller.
// stall_cnt/flush_cnt exist only when HAZ_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_mem_read;
  logic [REG_AW-1:0] mem_rd;
  logic              id_jump;
  logic              id_jr;
  logic              id_branch;
  logic              br_taken;
  logic              pc_write;
  logic              if_write;
  logic              bubble;
  logic [1:0]        addr_sel;
  logic              hz_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
           mem_mem_read, mem_rd, id_jump, id_jr, id_branch, br_taken,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt, flush_cnt,
`endif
    input  pc_write, if_write, bubble, addr_sel, hz_busy
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd,
           mem_mem_read, mem_rd, id_jump, id_jr, id_branch, br_taken,
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt, flush_cnt,
`endif
    output pc_write, if_write, bubble, addr_sel, hz_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall and jump/branch redirect sequencer for the 5-stage MIPS pipeline.
// Optional perf counters (stall_cnt/flush_cnt) enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_AW         = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int BR_RESOLVE_CYC = 1,
  parameter int CNT_W          = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  pipeline_hazard_ctrl_if.slave hz
);

  if (LOAD_STALL_CYC < 1 || LOAD_STALL_CYC > 3) begin : g_bad_load_cyc
    $error("pipeline_hazard_ctrl: LOAD_STALL_CYC must be 1..3");
  end
  if (BR_RESOLVE_CYC < 1 || BR_RESOLVE_CYC > 4) begin : g_bad_br_cyc
    $error("pipeline_hazard_ctrl: BR_RESOLVE_CYC must be 1..4");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipeline_hazard_ctrl: CNT_W must be at least 1");
  end

  localparam logic [REG_AW-1:0] ZERO_REG   = '0;
  localparam logic [1:0]        LD_EX_CNT  = 2'(LOAD_STALL_CYC - 1);
  localparam logic [1:0]        LD_MEM_CNT = (LOAD_STALL_CYC >= 2) ? 2'(LOAD_STALL_CYC - 2) : 2'd0;
  localparam logic [1:0]        BR_CNT     = 2'(BR_RESOLVE_CYC - 1);
  // A load in MEM only still needs a stall when its data arrives later than the forwarding path.
  localparam logic              MEM_CHK_EN = (LOAD_STALL_CYC >= 2);

  typedef enum logic [2:0] {IDLE, LD_STALL, JUMP, BR_WAIT, BR_REDIR} state_t;

  state_t     state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic       jr_reg, jr_next;
  logic       pc_write_reg, if_write_reg, bubble_reg, hz_busy_reg;
  logic [1:0] addr_sel_reg;
  logic       ld_ex, ld_mem;

  assign ld_ex  = hz.ex_mem_read && (hz.ex_rd != ZERO_REG) &&
                  ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
                   (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));
  assign ld_mem = MEM_CHK_EN && hz.mem_mem_read && (hz.mem_rd != ZERO_REG) &&
                  ((hz.id_use_rs && (hz.id_rs == hz.mem_rd)) ||
                   (hz.id_use_rt && (hz.id_rt == hz.mem_rd)));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    jr_next    = jr_reg;
    case (state_reg)
      IDLE: begin
        if (ld_ex) begin
          state_next = LD_STALL;
          cnt_next   = LD_EX_CNT;
        end else if (ld_mem) begin
          state_next = LD_STALL;
          cnt_next   = LD_MEM_CNT;
        end else if (hz.id_jump || hz.id_jr) begin
          state_next = JUMP;
          jr_next    = hz.id_jr;
        end else if (hz.id_branch) begin
          state_next = BR_WAIT;
          cnt_next   = BR_CNT;
        end
      end
      LD_STALL: begin
        if (cnt_reg != 2'd0) cnt_next = cnt_reg - 2'd1;
        else                 state_next = IDLE;
      end
      BR_WAIT: begin
        if (cnt_reg != 2'd0) cnt_next = cnt_reg - 2'd1;
        else                 state_next = hz.br_taken ? BR_REDIR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still Moore.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 2'd0;
      jr_reg       <= 1'b0;
      pc_write_reg <= 1'b1;
      if_write_reg <= 1'b1;
      bubble_reg   <= 1'b0;
      addr_sel_reg <= 2'b00;
      hz_busy_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      jr_reg      <= jr_next;
      hz_busy_reg <= (state_next != IDLE);
      case (state_next)
        LD_STALL, BR_WAIT: begin
          pc_write_reg <= 1'b0;
          if_write_reg <= 1'b0;
          bubble_reg   <= 1'b1;
          addr_sel_reg <= 2'b00;
        end
        JUMP: begin
          pc_write_reg <= 1'b1;
          if_write_reg <= 1'b0;
          bubble_reg   <= 1'b1;
          addr_sel_reg <= jr_next ? 2'b11 : 2'b01;
        end
        BR_REDIR: begin
          pc_write_reg <= 1'b1;
          if_write_reg <= 1'b0;
          bubble_reg   <= 1'b1;
          addr_sel_reg <= 2'b10;
        end
        default: begin
          pc_write_reg <= 1'b1;
          if_write_reg <= 1'b1;
          bubble_reg   <= 1'b0;
          addr_sel_reg <= 2'b00;
        end
      endcase
    end
  end

  assign hz.pc_write = pc_write_reg;
  assign hz.if_write = if_write_reg;
  assign hz.bubble   = bubble_reg;
  assign hz.addr_sel = addr_sel_reg;
  assign hz.hz_busy  = hz_busy_reg;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((state_reg == LD_STALL || state_reg == BR_WAIT) && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if ((state_next == JUMP || state_next == BR_REDIR) && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_reg;
  assign hz.flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (latencies 1/1 and 2/2) share stimulus and are
// checked against a schedule-queue model; perf counters are checked when HAZ_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, ex_mem_read, mem_mem_read;
  logic       id_jump, id_jr, id_branch, br_taken;
  int         vecs = 0;
  int         errs = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifs [2] ();
  logic [5:0] out_v [2];
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_v [2];
  logic [15:0] flush_v [2];
`endif

  // Instance gi uses LOAD_STALL_CYC = BR_RESOLVE_CYC = gi+1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign ifs[gi].id_rs        = id_rs;
    assign ifs[gi].id_rt        = id_rt;
    assign ifs[gi].id_use_rs    = id_use_rs;
    assign ifs[gi].id_use_rt    = id_use_rt;
    assign ifs[gi].ex_mem_read  = ex_mem_read;
    assign ifs[gi].ex_rd        = ex_rd;
    assign ifs[gi].mem_mem_read = mem_mem_read;
    assign ifs[gi].mem_rd       = mem_rd;
    assign ifs[gi].id_jump      = id_jump;
    assign ifs[gi].id_jr        = id_jr;
    assign ifs[gi].id_branch    = id_branch;
    assign ifs[gi].br_taken     = br_taken;
    assign out_v[gi] = {ifs[gi].pc_write, ifs[gi].if_write, ifs[gi].bubble,
                        ifs[gi].addr_sel, ifs[gi].hz_busy};
`ifdef HAZ_PERF_CNT_EN
    assign stall_v[gi] = ifs[gi].stall_cnt;
    assign flush_v[gi] = ifs[gi].flush_cnt;
`endif
    pipeline_hazard_ctrl #(
      .REG_AW(5), .LOAD_STALL_CYC(gi + 1), .BR_RESOLVE_CYC(gi + 1), .CNT_W(16)
    ) u_dut (
      .Clk(Clk),
      .Rst(Rst),
      .hz (ifs[gi])
    );
  end

  // Reference model: each detected event schedules the exact list of output cycles it causes.
  typedef struct packed {
    logic [4:0] o;      // {pc_write, if_write, bubble, addr_sel}
    logic       brfin;  // last branch-resolve cycle: br_taken decides a redirect
    logic       stall;
    logic       redir;
  } ent_t;

  ent_t sched [2][8];
  int   m_n     [2] = '{0, 0};
  ent_t m_cur   [2];
  logic m_busy  [2] = '{1'b0, 1'b0};
  int   m_stall [2] = '{0, 0};
  int   m_flush [2] = '{0, 0};

  function automatic ent_t mk(input logic [4:0] o, input logic brfin, input logic stall, input logic redir);
    ent_t e;
    e.o = o; e.brfin = brfin; e.stall = stall; e.redir = redir;
    return e;
  endfunction

  function automatic logic [5:0] exp_v(input int k);
    return {m_cur[k].o, m_busy[k]};
  endfunction

  task automatic m_push(input int k, input ent_t e);
    sched[k][m_n[k]] = e;
    m_n[k]++;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_cur[k] = mk(5'b11000, 0, 0, 0); m_busy[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  task automatic m_step(input int k);
    int   lat;
    logic ldex, ldmem;
    lat = k + 1;
    if (m_busy[k]) begin
      if (m_cur[k].stall) m_stall[k]++;
      if (m_cur[k].brfin && br_taken) m_push(k, mk(5'b10110, 0, 0, 1));
    end else begin
      ldex  = ex_mem_read && ex_rd != 0 &&
              ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      ldmem = lat >= 2 && mem_mem_read && mem_rd != 0 &&
              ((id_use_rs && id_rs == mem_rd) || (id_use_rt && id_rt == mem_rd));
      if (ldex)
        for (int i = 0; i < lat; i++) m_push(k, mk(5'b00100, 0, 1, 0));
      else if (ldmem)
        for (int i = 0; i < lat - 1; i++) m_push(k, mk(5'b00100, 0, 1, 0));
      else if (id_jump || id_jr)
        m_push(k, mk({3'b101, id_jr ? 2'b11 : 2'b01}, 0, 0, 1));
      else if (id_branch)
        for (int i = 0; i < lat; i++) m_push(k, mk(5'b00100, i == lat - 1, 1, 0));
    end
    if (m_n[k] > 0) begin
      m_cur[k] = sched[k][0];
      for (int i = 0; i < m_n[k] - 1; i++) sched[k][i] = sched[k][i + 1];
      m_n[k]--;
      m_busy[k] = 1'b1;
    end else begin
      m_cur[k]  = mk(5'b11000, 0, 0, 0);
      m_busy[k] = 1'b0;
    end
    if (m_busy[k] && m_cur[k].redir) m_flush[k]++;
  endtask

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) m_reset();
    else begin
      m_step(0);
      m_step(1);
    end
  end

  task automatic clr();
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0; mem_mem_read = 0;
    id_jump = 0; id_jr = 0; id_branch = 0; br_taken = 0;
  endtask

  task automatic test_reset();
    clr();
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (out_v[k] !== 6'b110000) begin
        errs++; $display("FAIL reset inst%0d: got %b want 110000", k, out_v[k]);
      end
    end
    Rst = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (out_v[k] !== exp_v(k)) begin
        errs++; $display("FAIL reset_release inst%0d: got %b want %b", k, out_v[k], exp_v(k));
      end
    end
  endtask

  task automatic test_load_use();
    // adjacent use (ex), one-between use (mem), and a zero destination
    for (int s = 0; s < 3; s++) begin
      clr();
      id_use_rs = 1; id_rs = 5;
      if (s == 0) begin ex_mem_read = 1;  ex_rd = 5;  end
      if (s == 1) begin mem_mem_read = 1; mem_rd = 5; end
      if (s == 2) begin ex_mem_read = 1;  ex_rd = 0; id_rs = 0; end
      @(negedge Clk);
      if (s == 0) begin
        vecs++;
        if (out_v[0] !== 6'b001001) begin
          errs++; $display("FAIL load_use_t1 inst0: got %b want 001001", out_v[0]);
        end
      end
      clr();
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 2; k++) begin
          vecs++;
          if (out_v[k] !== exp_v(k)) begin
            errs++; $display("FAIL load_use s%0d c%0d inst%0d: got %b want %b", s, c, k, out_v[k], exp_v(k));
          end
        end
        @(negedge Clk);
      end
    end
  endtask

  task automatic test_use_rt();
    clr();
    ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_use_rt = 0; id_rs = 2; id_use_rs = 1;
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (out_v[k] !== 6'b110000) begin
        errs++; $display("FAIL use_rt_off inst%0d: got %b want 110000", k, out_v[k]);
      end
    end
    id_rs = 7;
    @(negedge Clk);
    clr();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (out_v[k] !== exp_v(k) || (c == 0 && out_v[k] !== 6'b001001)) begin
          errs++; $display("FAIL use_rs_on c%0d inst%0d: got %b want %b", c, k, out_v[k], exp_v(k));
        end
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      clr();
      id_branch = 1; br_taken = 1'(t);
      @(negedge Clk);
      id_branch = 0;
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 2; k++) begin
          vecs++;
          if (out_v[k] !== exp_v(k)) begin
            errs++; $display("FAIL branch taken%0d c%0d inst%0d: got %b want %b", t, c, k, out_v[k], exp_v(k));
          end
        end
        if (c == 2) begin
          vecs++;
          if (out_v[1] !== (t == 1 ? 6'b101101 : 6'b110000)) begin
            errs++; $display("FAIL branch_lat2 taken%0d: got %b want %b", t, out_v[1],
                             (t == 1 ? 6'b101101 : 6'b110000));
          end
        end
        @(negedge Clk);
      end
    end
  endtask

  task automatic test_jr_load();
    for (int c = 0; c < 6; c++) begin
      clr();
      if (c < 3) begin id_jr = 1; id_use_rs = 1; id_rs = 3; end
      if (c == 0) begin ex_mem_read = 1;  ex_rd = 3;  end
      if (c == 1) begin mem_mem_read = 1; mem_rd = 3; end
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (out_v[k] !== exp_v(k)) begin
          errs++; $display("FAIL jr_load c%0d inst%0d: got %b want %b", c, k, out_v[k], exp_v(k));
        end
      end
      if (c == 0 || c == 2) begin
        vecs++;
        if (out_v[0] !== (c == 0 ? 6'b001001 : 6'b101111)) begin
          errs++; $display("FAIL jr_load_seq c%0d inst0: got %b want %b", c, out_v[0],
                           (c == 0 ? 6'b001001 : 6'b101111));
        end
      end
    end
    clr();
  endtask

  task automatic test_reset_mid();
    clr();
    id_branch = 1;
    @(negedge Clk);
    clr();
    vecs++;
    if (out_v[1] !== 6'b001001) begin
      errs++; $display("FAIL reset_mid_pre inst1: got %b want 001001", out_v[1]);
    end
    #2 Rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (out_v[k] !== 6'b110000) begin
        errs++; $display("FAIL reset_mid inst%0d: got %b want 110000", k, out_v[k]);
      end
`ifdef HAZ_PERF_CNT_EN
      vecs++;
      if (stall_v[k] !== 16'd0 || flush_v[k] !== 16'd0) begin
        errs++; $display("FAIL reset_mid_cnt inst%0d: got %0d/%0d want 0/0", k, stall_v[k], flush_v[k]);
      end
`endif
    end
    #1 Rst = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (out_v[k] !== 6'b110000) begin
        errs++; $display("FAIL reset_mid_after inst%0d: got %b want 110000", k, out_v[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 3) == 0);
      mem_mem_read = ($urandom_range(0, 3) == 0);
      id_jump      = ($urandom_range(0, 7) == 0);
      id_jr        = ($urandom_range(0, 7) == 0);
      id_branch    = ($urandom_range(0, 4) == 0);
      br_taken     = 1'($urandom_range(0, 1));
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
        vecs++;
        if (out_v[k] !== exp_v(k)) begin
          errs++; $display("FAIL random c%0d inst%0d: got %b want %b", c, k, out_v[k], exp_v(k));
        end
`ifdef HAZ_PERF_CNT_EN
        vecs++;
        if (stall_v[k] !== 16'(m_stall[k]) || flush_v[k] !== 16'(m_flush[k])) begin
          errs++; $display("FAIL random_cnt c%0d inst%0d: got %0d/%0d want %0d/%0d", c, k,
                           stall_v[k], flush_v[k], m_stall[k], m_flush[k]);
        end
`endif
      end
    end
    clr();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_load_use();
    test_use_rt();
    test_branch();
    test_jr_load();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
